// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake and RAM control bundle.
// Latency: none, wires only.
// Backpressure: ReqReady gates requests; responses and RAM controls are never stalled.
// Ports: Req* pipeline request, Rsp* response pulse, Mem* data RAM controls plus MemDataOut.
// slave = the controller, master = the requester together with the RAM.
interface mem_access_ctrl_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [8:0]  ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspError;
  logic        MemEnable;
  logic        MemReadWrite;
  logic        MemSignExtend;
  logic [1:0]  MemSize;
  logic [8:0]  MemAddress;
  logic [31:0] MemDataIn;
  logic [31:0] MemDataOut;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemDataOut,
    output ReqReady, RspValid, RspData, RspError,
           MemEnable, MemReadWrite, MemSignExtend, MemSize, MemAddress, MemDataIn
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemDataOut,
    input  ReqReady, RspValid, RspData, RspError,
           MemEnable, MemReadWrite, MemSignExtend, MemSize, MemAddress, MemDataIn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for the big-endian 512x8 data RAM.
// Latency: legal access responds WAIT_CYCLES+1 cycles after accept, illegal access 1 cycle.
// Backpressure: ReqReady only in IDLE; the response is a one-cycle pulse that is never stalled.
// Ports: Clk, Reset (synchronous, active-high); bus (slave modport): Req* request handshake,
//   Rsp* registered response, Mem* registered RAM controls, MemDataOut RAM read data.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter counts down to zero, so an access spends exactly WAIT_CYCLES cycles in ACCESS.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       req_err;

  assign bus.ReqReady = (state == IDLE);
  assign accept       = bus.ReqValid && (state == IDLE);

  // Illegal size or an address not aligned to the access size.
  always_comb begin
    req_err = 1'b0;
    case (bus.ReqSize)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus.ReqAddr[0];
      2'b10:   req_err = |bus.ReqAddr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Address/size/data/sign-extend hold their last values outside ACCESS;
  // only Enable and ReadWrite are dropped, so the RAM never sees a stray write strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt               <= 4'd0;
      bus.RspValid      <= 1'b0;
      bus.RspError      <= 1'b0;
      bus.RspData       <= 32'd0;
      bus.MemEnable     <= 1'b0;
      bus.MemReadWrite  <= 1'b0;
      bus.MemSignExtend <= 1'b0;
      bus.MemSize       <= 2'd0;
      bus.MemAddress    <= 9'd0;
      bus.MemDataIn     <= 32'd0;
    end else begin
      bus.RspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              bus.RspValid <= 1'b1;
              bus.RspError <= 1'b1;
              bus.RspData  <= 32'd0;
            end else begin
              bus.MemEnable     <= 1'b1;
              bus.MemReadWrite  <= bus.ReqWrite;
              // Words and stores never sign-extend.
              bus.MemSignExtend <= bus.ReqSigned && !bus.ReqWrite && (bus.ReqSize != 2'b10);
              bus.MemSize       <= bus.ReqSize;
              bus.MemAddress    <= bus.ReqAddr;
              bus.MemDataIn     <= bus.ReqWData;
              cnt               <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            bus.RspValid     <= 1'b1;
            bus.RspError     <= 1'b0;
            bus.RspData      <= bus.MemReadWrite ? 32'd0 : bus.MemDataOut;
            bus.MemEnable    <= 1'b0;
            bus.MemReadWrite <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a byte-array model.
// Latency: two DUT instances, WAIT_CYCLES=1 and WAIT_CYCLES=4, selected by 'sel'.
// Backpressure: requests are held until ReqReady; the RAM model answers every access.
module tb_mem_access_ctrl;

  logic Clk;
  logic Reset;
  logic ram_init;
  bit   sel;

  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_ctrl_if if1 ();
  mem_access_ctrl_if if4 ();

  mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(if1.slave));
  mem_access_ctrl #(.WAIT_CYCLES(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(if4.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign if1.ReqValid  = req_valid & ~sel;
  assign if4.ReqValid  = req_valid & sel;
  assign if1.ReqWrite  = req_write;
  assign if4.ReqWrite  = req_write;
  assign if1.ReqSize   = req_size;
  assign if4.ReqSize   = req_size;
  assign if1.ReqSigned = req_signed;
  assign if4.ReqSigned = req_signed;
  assign if1.ReqAddr   = req_addr;
  assign if4.ReqAddr   = req_addr;
  assign if1.ReqWData  = req_wdata;
  assign if4.ReqWData  = req_wdata;

  // Observed outputs of the selected DUT.
  logic        o_rdy, o_rsp, o_err, o_en, o_rw, o_sx;
  logic [31:0] o_data, o_din;
  logic [1:0]  o_sz;
  logic [8:0]  o_addr;
  assign o_rdy  = sel ? if4.ReqReady      : if1.ReqReady;
  assign o_rsp  = sel ? if4.RspValid      : if1.RspValid;
  assign o_err  = sel ? if4.RspError      : if1.RspError;
  assign o_data = sel ? if4.RspData       : if1.RspData;
  assign o_en   = sel ? if4.MemEnable     : if1.MemEnable;
  assign o_rw   = sel ? if4.MemReadWrite  : if1.MemReadWrite;
  assign o_sx   = sel ? if4.MemSignExtend : if1.MemSignExtend;
  assign o_sz   = sel ? if4.MemSize       : if1.MemSize;
  assign o_addr = sel ? if4.MemAddress    : if1.MemAddress;
  assign o_din  = sel ? if4.MemDataIn     : if1.MemDataIn;

  // All registered outputs of each DUT, for the reset checks.
  logic [79:0] outs [2];
  assign outs[0] = {if1.RspValid, if1.RspError, if1.RspData, if1.MemEnable, if1.MemReadWrite,
                    if1.MemSignExtend, if1.MemSize, if1.MemAddress, if1.MemDataIn};
  assign outs[1] = {if4.RspValid, if4.RspError, if4.RspData, if4.MemEnable, if4.MemReadWrite,
                    if4.MemSignExtend, if4.MemSize, if4.MemAddress, if4.MemDataIn};

  // Big-endian 512x8 RAM, one per DUT.
  logic        m_en [2];
  logic        m_rw [2];
  logic        m_sx [2];
  logic [1:0]  m_sz [2];
  logic [8:0]  m_addr [2];
  logic [31:0] m_din [2];
  logic [31:0] rdata [2];
  logic [7:0]  ram [2][512];

  assign m_en[0] = if1.MemEnable;      assign m_en[1] = if4.MemEnable;
  assign m_rw[0] = if1.MemReadWrite;   assign m_rw[1] = if4.MemReadWrite;
  assign m_sx[0] = if1.MemSignExtend;  assign m_sx[1] = if4.MemSignExtend;
  assign m_sz[0] = if1.MemSize;        assign m_sz[1] = if4.MemSize;
  assign m_addr[0] = if1.MemAddress;   assign m_addr[1] = if4.MemAddress;
  assign m_din[0] = if1.MemDataIn;     assign m_din[1] = if4.MemDataIn;
  assign if1.MemDataOut = rdata[0];
  assign if4.MemDataOut = rdata[1];

  always @(posedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_init) begin
        for (int i = 0; i < 512; i++) ram[d][i] <= 8'(i * 13 + 7);
      end else if (m_en[d] && m_rw[d]) begin
        case (m_sz[d])
          2'd0: ram[d][m_addr[d]] <= m_din[d][7:0];
          2'd1: begin
            ram[d][m_addr[d]]        <= m_din[d][15:8];
            ram[d][m_addr[d] + 9'd1] <= m_din[d][7:0];
          end
          default: for (int i = 0; i < 4; i++) ram[d][m_addr[d] + 9'(i)] <= m_din[d][8*(3-i) +: 8];
        endcase
      end
    end
  end

  function automatic logic [31:0] ram_rd(input int d);
    logic [8:0] a;
    logic [7:0] b0, b1;
    a  = m_addr[d];
    b0 = ram[d][a];
    b1 = ram[d][a + 9'd1];
    case (m_sz[d])
      2'd0:    ram_rd = m_sx[d] ? {{24{b0[7]}}, b0} : {24'd0, b0};
      2'd1:    ram_rd = m_sx[d] ? {{16{b0[7]}}, b0, b1} : {16'd0, b0, b1};
      default: ram_rd = {b0, b1, ram[d][a + 9'd2], ram[d][a + 9'd3]};
    endcase
  endfunction

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) rdata[d] <= ram_rd(d);
  end

  // Reference model: plain byte arrays, updated when a legal store is accepted.
  logic [7:0] ref_mem [2][512];

  function automatic logic [31:0] model_load(input int d, input int a, input int sz, input bit sg);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[d][(a + i) % 512]);
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int d, input int a, input int sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[d][(a + i) % 512] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  function automatic bit model_err(input int a, input int sz);
    return (sz == 3) || ((a % (1 << sz)) != 0);
  endfunction

  typedef struct {
    int          rsp_c;
    int          en_cnt;
    int          en_first;
    int          en_last;
    int          rdy_hi;
    bit          fld_bad;
    logic [31:0] data;
    logic        err;
  } obs_t;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Present one request, wait for acceptance, and record what the selected DUT does
  // in each cycle after the accept edge until its response pulse.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                        input logic [31:0] wd, output obs_t o);
    int  n;
    logic exp_sx;
    o = '{default: 0};
    exp_sx = sg && !w && (sz != 2'b10);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    n = 0;
    while (!o_rdy && n < 50) begin cyc(); n++; end
    cyc();
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (o_en) begin
        if (o.en_cnt == 0) o.en_first = c;
        o.en_last = c;
        o.en_cnt++;
        if (o_addr !== a || o_sz !== sz || o_rw !== w || o_din !== wd || o_sx !== exp_sx) o.fld_bad = 1;
      end
      if (o_rdy) o.rdy_hi++;
      if (o_rsp) begin
        o.rsp_c = c; o.data = o_data; o.err = o_err;
        break;
      end
      cyc();
    end
    cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b1; ram_init = 1'b1; req_valid = 1'b0; sel = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 9'd0; req_wdata = 32'd0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++) ref_mem[d][i] = 8'((i * 13 + 7) % 256);
    cyc(); cyc();
    ram_init = 1'b0; Reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (outs[d] !== 80'd0) $display("FAIL reset_outs dut%0d got=%h exp=0", d, outs[d]); else n_pass++;
    end
    n_checks++; if (if1.ReqReady !== 1'b1 || if4.ReqReady !== 1'b1)
      $display("FAIL reset_ready got=%b%b exp=11", if1.ReqReady, if4.ReqReady); else n_pass++;
  endtask

  task automatic test_store_load_word();
    obs_t o;
    sel = 1'b0;
    do_req(1'b1, 2'd2, 1'b0, 9'h00C, 32'hDEADBEEF, o);
    model_store(0, 12, 2, 32'hDEADBEEF);
    n_checks++; if (o.rsp_c !== 2) $display("FAIL sw_latency got=%0d exp=2", o.rsp_c); else n_pass++;
    n_checks++; if (o.en_cnt !== 1 || o.en_first !== 1) $display("FAIL sw_enable got=%0d@%0d exp=1@1", o.en_cnt, o.en_first); else n_pass++;
    n_checks++; if (o.fld_bad) $display("FAIL sw_fields got=bad exp=ok"); else n_pass++;
    n_checks++; if (o.data !== 32'd0 || o.err !== 1'b0) $display("FAIL sw_rsp got=%h/%b exp=0/0", o.data, o.err); else n_pass++;
    n_checks++; if (o.rdy_hi !== 0) $display("FAIL sw_ready_busy got=%0d exp=0", o.rdy_hi); else n_pass++;
    do_req(1'b0, 2'd2, 1'b0, 9'h00C, 32'd0, o);
    n_checks++; if (o.data !== 32'hDEADBEEF || o.rsp_c !== 2)
      $display("FAIL lw_data got=%h@%0d exp=deadbeef@2", o.data, o.rsp_c); else n_pass++;
  endtask

  task automatic test_subword_loads();
    obs_t o;
    logic [8:0]  ta [4] = '{9'h00C, 9'h00C, 9'h00E, 9'h00E};
    logic [1:0]  ts [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        tg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000BEEF};
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, ts[i], tg[i], ta[i], 32'd0, o);
      n_checks++; if (o.data !== te[i] || o.err !== 1'b0 || o.fld_bad)
        $display("FAIL subword_%0d got=%h/%b exp=%h/0", i, o.data, o.err, te[i]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [8:0] ea [3] = '{9'h00D, 9'h00E, 9'h000};
    logic [1:0] es [3] = '{2'd1, 2'd2, 2'd3};
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, es[i], 1'b0, ea[i], 32'h12345678, o);
      n_checks++; if (o.rsp_c !== 1) $display("FAIL err%0d_latency got=%0d exp=1", i, o.rsp_c); else n_pass++;
      n_checks++; if (o.err !== 1'b1 || o.data !== 32'd0)
        $display("FAIL err%0d_rsp got=%h/%b exp=0/1", i, o.data, o.err); else n_pass++;
      n_checks++; if (o.en_cnt !== 0 || o.rdy_hi !== 0)
        $display("FAIL err%0d_enable got=en%0d rdy%0d exp=0/0", i, o.en_cnt, o.rdy_hi); else n_pass++;
    end
  endtask

  task automatic test_random(input bit use4, input int n);
    obs_t o;
    logic w, sg;
    logic [1:0] sz;
    logic [8:0] a;
    logic [31:0] wd, exp;
    bit err;
    int wc, d;
    sel = use4; wc = use4 ? 4 : 1; d = use4 ? 1 : 0;
    for (int k = 0; k < n; k++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 9'($urandom_range(0, 63));
      wd = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = 9'(int'(a) - (int'(a) % (1 << sz)));
      err = model_err(int'(a), int'(sz));
      exp = (err || w) ? 32'd0 : model_load(d, int'(a), int'(sz), sg);
      do_req(w, sz, sg, a, wd, o);
      if (!err && w) model_store(d, int'(a), int'(sz), wd);
      n_checks++; if (o.err !== err || o.data !== exp)
        $display("FAIL rand_w%0d_%0d_rsp got=%h/%b exp=%h/%b", wc, k, o.data, o.err, exp, err); else n_pass++;
      n_checks++; if (o.rsp_c !== (err ? 1 : wc + 1))
        $display("FAIL rand_w%0d_%0d_latency got=%0d exp=%0d", wc, k, o.rsp_c, err ? 1 : wc + 1); else n_pass++;
      n_checks++; if (o.en_cnt !== (err ? 0 : wc) || (!err && (o.en_first !== 1 || o.en_last !== wc)) || o.fld_bad)
        $display("FAIL rand_w%0d_%0d_enable got=%0d@%0d..%0d exp=%0d", wc, k, o.en_cnt, o.en_first, o.en_last, err ? 0 : wc); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int acc[$];
    int en_cyc, rdy_busy, rsp_n, idx;
    logic rdy_b;
    logic [31:0] wd [3];
    logic [31:0] exp;
    sel = 1'b1;
    en_cyc = 0; rdy_busy = 0; rsp_n = 0; idx = 0;
    for (int i = 0; i < 3; i++) wd[i] = $urandom;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 9'h1F0; req_wdata = wd[0];
    for (int c = 0; c < 24; c++) begin
      rdy_b = o_rdy;
      cyc();
      if (rdy_b && req_valid) begin
        acc.push_back(c);
        model_store(1, int'(req_addr), 0, req_wdata);
        idx++;
        if (idx == 3) req_valid = 1'b0;
        else begin req_addr = 9'h1F0 + 9'(idx); req_wdata = wd[idx]; end
      end
      if (o_en) en_cyc++;
      if ((o_en || o_rsp) && o_rdy) rdy_busy++;
      if (o_rsp) rsp_n++;
    end
    n_checks++; if (acc.size() != 3) $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); else n_pass++;
    if (acc.size() == 3) begin
      n_checks++; if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6)
        $display("FAIL b2b_spacing got=%0d,%0d exp=6,6", acc[1] - acc[0], acc[2] - acc[1]); else n_pass++;
    end
    n_checks++; if (en_cyc != 12) $display("FAIL b2b_enable got=%0d exp=12", en_cyc); else n_pass++;
    n_checks++; if (rdy_busy != 0) $display("FAIL b2b_ready_busy got=%0d exp=0", rdy_busy); else n_pass++;
    n_checks++; if (rsp_n != 3) $display("FAIL b2b_responses got=%0d exp=3", rsp_n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      exp = model_load(1, 'h1F0 + i, 0, 1'b0);
      do_req(1'b0, 2'd0, 1'b0, 9'h1F0 + 9'(i), 32'd0, o);
      n_checks++; if (o.data !== exp) $display("FAIL b2b_readback%0d got=%h exp=%h", i, o.data, exp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int n, rsp_n;
    logic [31:0] exp;
    sel = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 9'h040;
    n = 0;
    while (!o_rdy && n < 50) begin cyc(); n++; end
    cyc();
    req_valid = 1'b0;
    cyc();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    n_checks++; if (o_en !== 1'b0 || o_rsp !== 1'b0 || o_rdy !== 1'b1)
      $display("FAIL abort_state got=en%b rsp%b rdy%b exp=en0 rsp0 rdy1", o_en, o_rsp, o_rdy); else n_pass++;
    rsp_n = 0;
    for (int c = 0; c < 8; c++) begin cyc(); if (o_rsp) rsp_n++; end
    n_checks++; if (rsp_n != 0) $display("FAIL abort_no_rsp got=%0d exp=0", rsp_n); else n_pass++;
    exp = model_load(1, 'h040, 2, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 9'h040, 32'd0, o);
    n_checks++; if (o.data !== exp || o.rsp_c !== 5 || o.err !== 1'b0)
      $display("FAIL abort_then_load got=%h@%0d exp=%h@5", o.data, o.rsp_c, exp); else n_pass++;
  endtask

  task automatic test_reset_release();
    obs_t o;
    logic [31:0] exp;
    sel = 1'b1;
    Reset = 1'b1;
    cyc(); cyc();
    Reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (outs[d] !== 80'd0) $display("FAIL release_outs dut%0d got=%h exp=0", d, outs[d]); else n_pass++;
    end
    n_checks++; if (if1.ReqReady !== 1'b1 || if4.ReqReady !== 1'b1)
      $display("FAIL release_ready got=%b%b exp=11", if1.ReqReady, if4.ReqReady); else n_pass++;
    exp = model_load(1, 'h1F1, 0, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 9'h1F1, 32'd0, o);
    n_checks++; if (o.rsp_c !== 5 || o.en_first !== 1 || o.data !== exp)
      $display("FAIL release_accept got=%h@%0d en@%0d exp=%h@5 en@1", o.data, o.rsp_c, o.en_first, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_subword_loads();
    test_errors();
    test_random(1'b0, 40);
    test_back_to_back();
    test_reset_mid_access();
    test_random(1'b1, 30);
    test_reset_release();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store initiator that drives the byte-addressed, big-endian 512x8 data RAM: Enable, ReadWrite, SignExtend, Size, Address and DataIn.
- Takes one request at a time from the MIPS pipeline over a valid/ready handshake.
- Checks alignment and size legality before touching memory.
- Holds the RAM controls stable for a programmable number of cycles.
- Returns a registered, single-cycle response pulse carrying load data or an error flag.

Parameters:
WAIT_CYCLES, 1, cycles MemEnable stays asserted per access (legal 1..15; counter is 4 bits)

Ports:
Clk  in  1  single clock, rising edge
Reset  in  1  synchronous, active-high reset
ReqValid  in  1  request present
ReqReady  out  1  controller can accept a request (high only in IDLE)
ReqWrite  in  1  1 = store, 0 = load
ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
ReqSigned  in  1  sign-extend loads (ignored for stores and words)
ReqAddr  in  9  byte address
ReqWData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
RspValid  out  1  one-cycle response pulse
RspData  out  32  load result (0 for stores and errors)
RspError  out  1  qualified by RspValid: misaligned or illegal size
MemEnable  out  1  RAM Enable
MemReadWrite  out  1  RAM ReadWrite (1 = write)
MemSignExtend  out  1  RAM SignExtend
MemSize  out  2  RAM Size
MemAddress  out  9  RAM Address
MemDataIn  out  32  RAM DataIn
MemDataOut  in  32  RAM DataOut

Behaviour:
- Reset is synchronous and active-high.
  - On reset: state=IDLE, counter=0.
  - RspValid=0, RspError=0, RspData=0.
  - All Mem* outputs = 0.
  - ReqReady=1 on the first cycle after reset is released.
- All outputs except ReqReady are registered. ReqReady is decoded from state as (state==IDLE).
- States:
  - IDLE: ReqReady=1. Accept on ReqValid&ReqReady at edge T.
    - Legal request: latch fields into the Mem* registers, set MemEnable=1, load counter=WAIT_CYCLES-1, go to ACCESS.
    - Illegal request: go to RESP with the error set. Mem* outputs unchanged, MemEnable stays 0.
  - ACCESS: Mem* outputs held constant. Counter decrements each cycle. When counter==0:
    - capture MemDataOut into RspData for loads, or 0 for stores;
    - clear MemEnable and MemReadWrite on the same edge;
    - go to RESP.
  - RESP: RspValid=1 for exactly one cycle, then IDLE.
- Latency:
  - Legal request accepted at edge T: MemEnable high for cycles T+1..T+WAIT_CYCLES; RspValid high in cycle T+WAIT_CYCLES+1.
  - Error request: RspValid in cycle T+1.
  - Throughput: one request per WAIT_CYCLES+2 cycles (legal) or 2 cycles (error).
- Legality:
  - Error if ReqSize==11.
  - Error if half and ReqAddr[0]==1.
  - Error if word and ReqAddr[1:0]!=00.
  - Aligned accesses never cross address 511, so no wrap-around check is needed.
- On error: RspError=1, RspData=0, MemEnable never asserted, no RAM state changes.
- Field mapping: MemSize=ReqSize, MemAddress=ReqAddr, MemDataIn=ReqWData unchanged, MemReadWrite=ReqWrite.
  - MemSignExtend=ReqSigned for loads.
  - MemSignExtend=0 for stores and for word loads.
- Idle outputs: outside ACCESS, MemEnable=0 and MemReadWrite=0. MemAddress, MemSize, MemDataIn and MemSignExtend hold their last values, so the RAM never sees a spurious write strobe.
- RspData and RspError hold until the next RESP. RspValid is not back-pressured.
- ReqValid while not in IDLE is ignored; the requester must hold it until ReqReady.
- Reset mid-ACCESS aborts the access:
  - MemEnable=0 on that edge.
  - No RspValid for the aborted request.
  - A partial store may already have updated the RAM; this is acceptable.
- Reset during RESP suppresses the remaining pulse: RspValid=0 after the edge.

Test Plan:
1. WAIT_CYCLES=1. Store word 0xDEADBEEF to 0x00C, then load word from 0x00C.
   - Store: MemEnable=1 with MemReadWrite=1 for exactly one cycle; RspValid at T+2 with RspData=0, RspError=0.
   - Load: RspData=0xDEADBEEF at T+2.
2. After scenario 1:
   - Load byte 0x00C signed -> 0xFFFFFFDE.
   - Load byte 0x00C unsigned -> 0x000000DE.
   - Load half 0x00E signed -> 0xFFFFBEEF.
   - Load half 0x00E unsigned -> 0x0000BEEF.
3. Misaligned and illegal requests:
   - Load half at 0x00D -> RspValid at T+1, RspError=1, RspData=0, MemEnable never high.
   - Word at 0x00E -> same response.
   - ReqSize=11 at 0x000 -> same response.
4. WAIT_CYCLES=4, ReqValid held high with three back-to-back byte stores to 0x1F0..0x1F2.
   - Accepts are 6 cycles apart.
   - MemEnable high for 4 cycles per access.
   - ReqReady low throughout ACCESS and RESP.
5. WAIT_CYCLES=4. Assert Reset in the 2nd ACCESS cycle of a word load.
   - Next cycle: MemEnable=0, RspValid=0, ReqReady=1.
   - A subsequent load completes normally.
6. Reset release check.
   - Cycle after release: every output listed above is 0 and ReqReady=1.
   - A request presented in that cycle is accepted.
